// File: rtl/segment_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with a debounced mode-select button.
// Optional macro SEG_BLANK_LEADING_ZERO_EN blanks leading zero digits (digit 0 always shown).
`timescale 1ns/1ps
module segment_scan_ctrl #(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic [31:0] seg_num,
  output logic [2:0]  mode,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             acc_q, acc_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      snap_q, snap_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_tick_q, frame_tick_d;
  logic             div_wrap;
  logic             frame_wrap;
  logic [3:0]       nibble;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'h40;
      4'h1: r = 7'h79;
      4'h2: r = 7'h24;
      4'h3: r = 7'h30;
      4'h4: r = 7'h19;
      4'h5: r = 7'h12;
      4'h6: r = 7'h02;
      4'h7: r = 7'h78;
      4'h8: r = 7'h00;
      4'h9: r = 7'h10;
      4'hA: r = 7'h08;
      4'hB: r = 7'h03;
      4'hC: r = 7'h46;
      4'hD: r = 7'h21;
      4'hE: r = 7'h06;
      default: r = 7'h0E;
    endcase
    return r;
  endfunction

  always_comb begin
    sync1_d  = btn_mode;
    sync2_d  = sync1_q;
    acc_d    = acc_q;
    db_cnt_d = '0;
    mode_d   = mode_q;
    // Counter only runs while the synchronized level disagrees with the accepted one.
    if (sync2_q != acc_q) begin
      if (db_cnt_q == DB_LAST) begin
        acc_d    = sync2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    if (acc_d && !acc_q) begin
      mode_d = (mode_q >= 3'd4) ? 3'd0 : mode_q + 3'd1;
    end
  end

  always_comb begin
    div_wrap     = (div_q == DIV_LAST);
    frame_wrap   = div_wrap && (idx_q == 3'd7);
    div_d        = div_wrap ? '0 : div_q + 1'b1;
    idx_d        = idx_q + {2'b00, div_wrap};
    snap_d       = frame_wrap ? seg_num : snap_q;
    frame_tick_d = frame_wrap;
    an_d         = ~(8'b0000_0001 << idx_q);
    nibble       = snap_q[{idx_q, 2'b00} +: 4];
    seg_d        = hex_decode(nibble);
`ifdef SEG_BLANK_LEADING_ZERO_EN
    if ((idx_q != 3'd0) && ((snap_q >> {idx_q, 2'b00}) == 32'd0)) begin
      seg_d = 7'h7F;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      acc_q        <= 1'b0;
      db_cnt_q     <= '0;
      mode_q       <= 3'd0;
      div_q        <= '0;
      idx_q        <= 3'd0;
      snap_q       <= 32'd0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      frame_tick_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      acc_q        <= acc_d;
      db_cnt_q     <= db_cnt_d;
      mode_q       <= mode_d;
      div_q        <= div_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign mode       = mode_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign frame_tick = frame_tick_q;

endmodule

// File: doc/segment_scan_ctrl.md
SEGMENT_SCAN_CTRL -- requirements
Module: segment_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 100000, SHALL set the clock cycles each digit is driven (range 2..2^20).
REQ-002 Parameter DEBOUNCE_CYCLES, default 2000000, SHALL set the consecutive stable cycles a button level needs before acceptance (range 2..2^24).
REQ-003 Ports SHALL be:
  clk  in  1  system clock; all state changes on its rising edge.
  rst  in  1  synchronous, active-high reset.
  btn_mode  in  1  raw asynchronous mode-select push button, active high.
  seg_num  in  32  value to display, 8 hex nibbles; nibble i = seg_num[4i+3:4i].
  mode  out  3  display-source select for the segment value mux, range 0..4.
  an  out  8  digit enables, active low; an[i] drives digit i (digit 0 rightmost).
  seg  out  7  cathodes {g,f,e,d,c,b,a}, active low.
  dp  out  1  decimal point, active low; constant 1.
  frame_tick  out  1  one-cycle pulse on each seg_num snapshot.

Function
REQ-004 btn_mode SHALL pass through a 2-flop synchronizer before any other use.
REQ-005 Debounce: a counter SHALL increment each cycle the synchronized level differs from the accepted level, and clear on any cycle it matches.
REQ-006 When the counter equals DEBOUNCE_CYCLES-1 and the mismatch persists, the next edge SHALL update the accepted level and clear the counter.
REQ-007 A 0->1 change of the accepted level SHALL advance mode on that same edge: 0->1->2->3->4->0; values 5..7 SHALL never appear.
REQ-008 With btn_mode held high, mode SHALL change exactly DEBOUNCE_CYCLES+2 rising edges after (inclusive) the first edge sampling btn_mode high; no further change until release and re-press.
REQ-009 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles, at either level, SHALL not change the accepted level or mode.
REQ-010 Scan divider div SHALL count 0..SCAN_DIV-1 and wrap; on wrap, digit index idx SHALL advance 0..7 and wrap 7->0.
REQ-011 Snapshot register snap SHALL load seg_num on the edge where div=SCAN_DIV-1 and idx=7; frame_tick SHALL be 1 in the following cycle only.
REQ-012 seg_num changes between snapshots SHALL have no effect on an/seg (no tearing within a frame).
REQ-013 Every cycle, registered outputs SHALL load an <= ~(8'b1 << idx) and seg <= hex decode of snap nibble idx (one-cycle latency from idx).
REQ-014 Hex decode (seg hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-015 Exactly one an bit SHALL be low at any time outside reset; all SCAN_DIV cycles of a digit SHALL show the same digit.
REQ-016 Button events and frame wraps on the same edge SHALL both take effect independently.

Reset
REQ-017 While rst=1 at an edge: mode=0, div=0, idx=0, snap=0, debounce counter=0, synchronizer and accepted level=0, an=8'hFF, seg=7'h7F, dp=1, frame_tick=0.
REQ-018 First edge after reset release SHALL drive an=8'hFE, seg=7'h40; the first frame displays 0 until the first snapshot.
REQ-019 Reset during a press SHALL discard it; a button held across reset release SHALL cause one mode advance per REQ-008.

Configuration
REQ-020 Macro SEG_BLANK_LEADING_ZERO_EN defined: digit i>0 SHALL output seg=7'h7F (an still scanned) when snap nibbles i..7 are all zero; digit 0 never blanked.
REQ-021 Macro undefined: all eight digits SHALL always be decoded per REQ-014.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=3)
REQ-022 Reset, seg_num=32'h1234ABCD -> frame 1 shows 0s; after first frame_tick, digit0 seg=21 (d), digit7 seg=79 (1); an sequence FE,FD,...,7F, 4 cycles each.
REQ-023 btn_mode high for 20 cycles -> mode 0->1 exactly 5 edges after first high sample; no second increment; five presses -> mode back to 0.
REQ-024 btn_mode high 2 cycles then low -> mode unchanged; toggling every cycle for 50 cycles -> mode unchanged.
REQ-025 seg_num changed mid-frame -> an/seg unchanged until next frame_tick, then new value shown.
REQ-026 SEG_BLANK_LEADING_ZERO_EN, seg_num=32'h0000_00A0 -> digits 7..2 seg=7F, digit1=08, digit0=40; without macro digits 7..2 seg=40.
REQ-027 rst asserted mid-frame at idx=5 with mode=3 -> next cycle an=FF, seg=7F, mode=0; scan restarts at digit 0.
